// File: rtl/raw_state_reader_if.sv
// Read-side channel of the raw state reader:
// request and response handshakes.
interface raw_state_reader_if #(
  parameter int COUNT_WIDTH = 32,
  parameter int IDX_WIDTH   = 4
);
  logic                   i__rd_valid;
  logic                   o__rd_ready;
  logic [IDX_WIDTH-1:0]   i__rd_idx;
  logic                   i__rd_clear;
  logic                   i__sweep_start;
  logic                   o__resp_valid;
  logic                   i__resp_ready;
  logic [IDX_WIDTH-1:0]   o__resp_idx;
  logic [COUNT_WIDTH-1:0] o__resp_data;
  logic                   o__resp_last;

  modport master (
    output i__rd_valid,
    output i__rd_idx,
    output i__rd_clear,
    output i__sweep_start,
    output i__resp_ready,
    input  o__rd_ready,
    input  o__resp_valid,
    input  o__resp_idx,
    input  o__resp_data,
    input  o__resp_last
  );

  modport slave (
    input  i__rd_valid,
    input  i__rd_idx,
    input  i__rd_clear,
    input  i__sweep_start,
    input  i__resp_ready,
    output o__rd_ready,
    output o__resp_valid,
    output o__resp_idx,
    output o__resp_data,
    output o__resp_last
  );
endinterface

// File: rtl/raw_state_reader.sv
// Control-plane readout of the raw atom state bank:
// single reads and full sweeps, optional clear-on-read.
module raw_state_reader #(
  parameter int COUNT_WIDTH = 32,
  parameter int DEPTH       = 16,
  parameter int IDX_WIDTH   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i__wr_en,
  input  logic [IDX_WIDTH-1:0]   i__wr_idx,
  input  logic [COUNT_WIDTH-1:0] i__wr_data,
  raw_state_reader_if.slave      rd,
  output logic                   o__busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SINGLE,
    S_SWEEP
  } state_t;

  localparam logic [IDX_WIDTH:0] PTR_END =
    (IDX_WIDTH+1)'(DEPTH);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST =
    IDX_WIDTH'(DEPTH-1);

  state_t r_state;
  state_t w_state_nx;

  logic [COUNT_WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_WIDTH:0]     r_ptr;
  logic                   r_clr;
  logic                   r_valid;
  logic                   r_last;
  logic [IDX_WIDTH-1:0]   r_idx;
  logic [COUNT_WIDTH-1:0] r_data;

  logic                   w_rd_ready;
  logic                   w_start_sweep;
  logic                   w_start_single;
  logic                   w_sweep_ld;
  logic                   w_load;
  logic                   w_hs;
  logic                   w_ld_clr;
  logic                   w_ld_last;
  logic [IDX_WIDTH-1:0]   w_ld_idx;
  logic [COUNT_WIDTH-1:0] w_ld_data;

  assign w_rd_ready = (r_state == S_IDLE) && !r_valid;
  assign w_start_sweep = w_rd_ready && rd.i__sweep_start;
  assign w_start_single = w_rd_ready
    && !rd.i__sweep_start && rd.i__rd_valid;
  assign w_hs = r_valid && rd.i__resp_ready;
  // r_ptr == DEPTH means every entry has been loaded
  assign w_sweep_ld = (r_state == S_SWEEP)
    && (r_ptr != PTR_END)
    && (!r_valid || rd.i__resp_ready);
  assign w_load = w_start_sweep
    || w_start_single || w_sweep_ld;

  always_comb begin
    w_ld_idx = r_ptr[IDX_WIDTH-1:0];
    w_ld_clr = r_clr;
    unique case (1'b1)
      w_start_sweep: begin
        w_ld_idx = '0;
        w_ld_clr = rd.i__rd_clear;
      end
      w_start_single: begin
        w_ld_idx = rd.i__rd_idx;
        w_ld_clr = rd.i__rd_clear;
      end
      default: ;
    endcase
  end

  // same-cycle pipeline write is forwarded
  assign w_ld_data =
    (i__wr_en && (i__wr_idx == w_ld_idx))
    ? i__wr_data : r_mem[w_ld_idx];
  assign w_ld_last = w_start_single
    || (w_ld_idx == IDX_LAST);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_sweep)
          w_state_nx = S_SWEEP;
        else if (w_start_single)
          w_state_nx = S_SINGLE;
      end
      S_SINGLE: begin
        if (w_hs) w_state_nx = S_IDLE;
      end
      S_SWEEP: begin
        if (w_hs && r_last) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // clear is the later assignment so it beats a same-index write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (i__wr_en)
        r_mem[i__wr_idx] <= i__wr_data;
      if (w_load && w_ld_clr)
        r_mem[w_ld_idx] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_clr <= 1'b0;
    end else if (w_start_sweep) begin
      r_ptr <= (IDX_WIDTH+1)'(1);
      r_clr <= rd.i__rd_clear;
    end else if (w_sweep_ld) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_idx   <= w_ld_idx;
      r_data  <= w_ld_data;
      r_last  <= w_ld_last;
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign rd.o__rd_ready   = w_rd_ready;
  assign rd.o__resp_valid = r_valid;
  assign rd.o__resp_idx   = r_idx;
  assign rd.o__resp_data  = r_data;
  assign rd.o__resp_last  = r_last;
  assign o__busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_raw_state_reader.sv
// Bench for raw_state_reader: directed scenarios plus
// random traffic against a transaction-level model.
module tb_raw_state_reader;
  localparam int CW = 32;
  localparam int D  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [CW-1:0] wr_data = '0;
  logic          busy;

  raw_state_reader_if #(
    .COUNT_WIDTH(CW),
    .IDX_WIDTH(IW)
  ) rif ();

  raw_state_reader #(
    .COUNT_WIDTH(CW),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i__wr_en(wr_en),
    .i__wr_idx(wr_idx),
    .i__wr_data(wr_data),
    .rd(rif),
    .o__busy(busy)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] m_mem [D];
  bit            m_busy, m_sweep, m_clr;
  bit            m_valid, m_last;
  int            m_idx, m_next;
  logic [CW-1:0] m_data;
  int            n_vec, n_err, n_hs;

  task automatic chk(string tag,
                     logic [CW-1:0] obs,
                     logic [CW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  // one clock: apply the rules to the model, then compare
  task automatic tick();
    bit            ld, lclr, hs, rdy;
    int            li;
    logic [CW-1:0] lv;
    ld = 0; lclr = 0; li = 0; lv = '0;
    hs = m_valid && rif.i__resp_ready;
    rdy = !m_busy && !m_valid;
    if (!rst_n) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_busy = 0; m_sweep = 0; m_valid = 0;
      m_idx = 0; m_data = '0; m_last = 0;
      m_next = 0;
    end else begin
      if (rdy && rif.i__sweep_start) begin
        ld = 1; li = 0;
        lclr = rif.i__rd_clear;
        m_clr = rif.i__rd_clear;
        m_busy = 1; m_sweep = 1; m_next = 1;
      end else if (rdy && rif.i__rd_valid) begin
        ld = 1; li = int'(rif.i__rd_idx);
        lclr = rif.i__rd_clear;
        m_busy = 1; m_sweep = 0;
      end else if (m_busy && m_sweep && m_next < D
                   && (!m_valid || rif.i__resp_ready)) begin
        ld = 1; li = m_next; lclr = m_clr;
        m_next++;
      end
      if (ld)
        lv = (wr_en && int'(wr_idx) == li)
             ? wr_data : m_mem[li];
      if (wr_en) m_mem[wr_idx] = wr_data;
      if (ld && lclr) m_mem[li] = '0;
      if (hs) n_hs++;
      if (ld) begin
        if (hs && m_last) m_busy = 1;
        m_valid = 1; m_idx = li; m_data = lv;
        m_last = !m_sweep || li == D-1;
      end else if (hs) begin
        m_valid = 0;
        if (m_last) m_busy = 0;
      end
    end
    @(posedge clk); #1;
    chk("valid", rif.o__resp_valid, m_valid);
    if (m_valid) begin
      chk("idx", rif.o__resp_idx, m_idx);
      chk("data", rif.o__resp_data, m_data);
      chk("last", rif.o__resp_last, m_last);
    end
    chk("rd_ready", rif.o__rd_ready,
        !m_busy && !m_valid);
    chk("busy", busy, m_busy);
  endtask

  task automatic idle_in();
    rif.i__rd_valid = 0;
    rif.i__sweep_start = 0;
    rif.i__rd_clear = 0;
    wr_en = 0;
  endtask

  task automatic drain(int lim);
    for (int k = 0; k < lim && m_busy; k++)
      tick();
    chk("drain_timeout", busy, 1'b0);
  endtask

  task automatic single(int idx, bit clr);
    rif.i__rd_valid = 1;
    rif.i__rd_idx = IW'(idx);
    rif.i__rd_clear = clr;
    tick();
    idle_in();
  endtask

  task automatic wr(int idx, logic [CW-1:0] v);
    wr_en = 1; wr_idx = IW'(idx); wr_data = v;
    tick();
    wr_en = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_hs = 0;
    idle_in();
    rif.i__rd_idx = '0;
    rif.i__resp_ready = 1;
    rst_n = 0;
    tick(); tick();
    chk("rst_idx", rif.o__resp_idx, '0);
    chk("rst_data", rif.o__resp_data, '0);
    chk("rst_last", rif.o__resp_last, '0);
    rst_n = 1;
    tick();

    // reset then read idx 5
    single(5, 0);
    chk("rd5_data", rif.o__resp_data, '0);
    drain(4); tick();

    // forwarding with clear
    wr(3, 32'h10);
    wr_en = 1; wr_idx = 3; wr_data = 32'h25;
    single(3, 1);
    chk("fwd_data", rif.o__resp_data, 32'h25);
    drain(4); tick();
    single(3, 0);
    chk("clr_data", rif.o__resp_data, '0);
    drain(4); tick();

    // backpressure
    wr(7, 32'hAB);
    rif.i__resp_ready = 0;
    single(7, 0);
    repeat (4) begin
      tick();
      chk("bp_data", rif.o__resp_data, 32'hAB);
    end
    rif.i__resp_ready = 1;
    drain(4); tick();

    // sweep with clear and late write
    for (int k = 0; k < D; k++) wr(k, CW'(k+1));
    n_hs = 0;
    rif.i__sweep_start = 1; rif.i__rd_clear = 1;
    tick();
    idle_in();
    for (int c = 1; c < 40 && m_busy; c++) begin
      if (c == 5) begin
        wr_en = 1; wr_idx = 12; wr_data = 32'h99;
      end
      tick();
      wr_en = 0;
      if (rif.o__resp_valid && rif.o__resp_idx == 12)
        chk("sweep12", rif.o__resp_data, 32'h99);
    end
    chk("sweep_cnt", n_hs, 16);
    chk("sweep_end", busy, 1'b0);
    rif.i__sweep_start = 1;
    tick();
    idle_in();
    for (int c = 0; c < 40 && m_busy; c++) begin
      tick();
      if (rif.o__resp_valid)
        chk("zero_sweep", rif.o__resp_data, '0);
    end
    chk("zero_end", busy, 1'b0);

    // start priority with toggling ready
    for (int k = 0; k < D; k++) wr(k, $urandom);
    n_hs = 0;
    rif.i__sweep_start = 1; rif.i__rd_valid = 1;
    rif.i__rd_idx = 9;
    tick();
    idle_in();
    for (int c = 0; c < 80 && m_busy; c++) begin
      rif.i__resp_ready = ~rif.i__resp_ready;
      wr_en = $urandom_range(0, 1);
      wr_idx = IW'($urandom);
      wr_data = $urandom;
      tick();
    end
    wr_en = 0;
    rif.i__resp_ready = 1;
    drain(40);
    chk("prio_cnt", n_hs, 16);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rif.i__rd_valid = $urandom_range(0, 1);
      rif.i__sweep_start = ($urandom_range(0, 15) == 0);
      rif.i__rd_idx = IW'($urandom);
      rif.i__rd_clear = $urandom_range(0, 1);
      rif.i__resp_ready = ($urandom_range(0, 3) != 0);
      wr_en = $urandom_range(0, 1);
      wr_idx = IW'($urandom);
      wr_data = $urandom;
      tick();
    end
    idle_in();
    rif.i__resp_ready = 1;
    drain(40); tick();

    // reset mid-sweep
    for (int k = 0; k < D; k++) wr(k, $urandom | 1);
    rif.i__sweep_start = 1;
    tick();
    idle_in();
    for (int c = 0; c < 20; c++) begin
      if (m_valid && m_idx == 6) break;
      tick();
    end
    chk("mid_idx", rif.o__resp_idx, 6);
    rst_n = 0;
    tick();
    chk("mid_valid", rif.o__resp_valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    rst_n = 1;
    tick();
    single(2, 0);
    chk("post_rst2", rif.o__resp_data, '0);
    drain(4); tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/raw_state_reader.md
# raw_state_reader

Control-plane readout port for a bank of raw (read-add-write) atom state registers. The packet pipeline writes entries through a never-stalling write port, fed by the atom's `o__write` result. The control plane reads entries back with a valid/ready handshake, either one index at a time or as a full-bank sweep, with optional clear-on-read. It sits beside the stateful atom stage and is the read end of the atom's state register.

## Interface
- `COUNT_WIDTH`, 32, width of each state entry
- `DEPTH`, 16, number of state entries; power of two, ≥ 2
- `IDX_WIDTH`, $clog2(DEPTH), index width (derived)

Ports:
- `clk`  in  1  clock; everything below is synchronous to its rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `i__wr_en`  in  1  pipeline write strobe
- `i__wr_idx`  in  IDX_WIDTH  write index
- `i__wr_data`  in  COUNT_WIDTH  write value (atom `o__write`)
- `i__rd_valid`  in  1  single-read request
- `o__rd_ready`  out  1  request accepted when high with `i__rd_valid` or `i__sweep_start`
- `i__rd_idx`  in  IDX_WIDTH  single-read index
- `i__rd_clear`  in  1  clear-on-read; sampled with the request or sweep start
- `i__sweep_start`  in  1  start a sweep of entries 0..DEPTH-1
- `o__resp_valid`  out  1  response valid
- `i__resp_ready`  in  1  response consumer ready
- `o__resp_idx`  out  IDX_WIDTH  index of the returned entry
- `o__resp_data`  out  COUNT_WIDTH  returned entry value
- `o__resp_last`  out  1  high on a single-read response and on the final sweep entry
- `o__busy`  out  1  state ≠ IDLE

## Operation
States:
- IDLE
- SINGLE: one response outstanding
- SWEEP: streaming entries

Write port:
- `i__wr_en` always commits `i__wr_data` to `i__wr_idx` at the clock edge, in every state.
- Plain overwrite, no arithmetic.

Request acceptance:
- `o__rd_ready = (state == IDLE) && !o__resp_valid`.
- `i__sweep_start` has priority over `i__rd_valid` when both are high.

Single read (IDLE→SINGLE):
- The output register loads `{idx, data, last=1}` from `i__rd_idx`.
- If `i__wr_en` targets the same index in the acceptance cycle, the response returns `i__wr_data` (forwarding).
- If `i__rd_clear` is high, the entry becomes 0 at that edge, overriding a same-cycle write to the same index. The forwarded value is still returned, so no count is lost.
- SINGLE→IDLE on the response handshake (`o__resp_valid && i__resp_ready`).

Sweep (IDLE→SWEEP):
- Latch the clear flag from `i__rd_clear`; set the internal pointer to 0.
- The output register loads entry `ptr` whenever `!o__resp_valid || i__resp_ready`, then `ptr` increments.
- Each entry is sampled, forwarded and optionally cleared exactly as for a single read, at its load edge.
- `o__resp_last` is high with `idx == DEPTH-1`. The handshake of that entry returns the block to IDLE.
- A write to an entry not yet loaded is visible in the sweep; a write to an entry already loaded is not.

Response hold:
- While `o__resp_valid && !i__resp_ready`, `o__resp_idx`, `o__resp_data` and `o__resp_last` are held stable.

Reset:
- All entries are 0; state is IDLE; the pointer is 0.
- `o__resp_valid`, `o__resp_idx`, `o__resp_data`, `o__resp_last` and `o__busy` are all 0.
- `o__rd_ready` is 1 on the cycle after reset deasserts.
- Reset mid-SINGLE or mid-SWEEP aborts the operation: `o__resp_valid` is 0 after the reset edge, and all entries are zeroed.

## Timing
- Single read accepted at edge N: `o__resp_valid` high after N.
- Handshake at edge M: `o__rd_ready` high after M, so the next request can be accepted at M+1. Maximum single-read rate is one per 2 cycles.
- Sweep started at edge N: entry 0 valid after N. With `i__resp_ready` held high, one entry per cycle, and entry DEPTH-1 valid after N+DEPTH-1.
- IDLE is reached at the final handshake edge.
- Write-to-read latency through the array is 1 cycle. Same-cycle forwarding gives 0 extra cycles.

## Test plan
- **Reset then read:** deassert reset, single read idx 5 → response `idx=5`, `data=0`, `last=1` one cycle after acceptance.
- **Forwarding with clear:** write idx 3 = 0x10; next cycle, read idx 3 with clear while writing idx 3 = 0x25 → response data 0x25; a follow-up read of idx 3 returns 0.
- **Backpressure:** single read idx 7 (value 0xAB) with `i__resp_ready` low for 4 cycles → resp fields stable at 0xAB; `o__rd_ready` low until 1 cycle after the handshake.
- **Sweep with clear and late write:** load entry k = k+1; sweep with clear and `i__resp_ready` held high → 16 responses, data 1..16, `last` only on idx 15. A write of 0x99 to idx 12 during sweep cycle 5 is returned for idx 12. A subsequent sweep returns all 0.
- **Start priority:** `i__sweep_start` and `i__rd_valid` high in the same cycle → sweep runs and the single request is not accepted; with `i__resp_ready` toggling every cycle, 16 ordered responses are delivered with no skips or duplicates.
- **Reset mid-sweep:** assert `rst_n`=0 after the idx-6 response → `o__resp_valid` is 0 next cycle; `o__busy` is 0; a read of idx 2 then returns 0.
